// File: rtl/ofm_read_controller.sv
`default_nettype none
// ============================================================================
//  Module      : ofm_read_controller
//  Description : Drains a finished layer's OFM out of the OFM DPRAM read port
//                (port A) and streams it to the host as INOUT_WIDTH beats over
//                a valid/ready handshake with per-beat element count and a
//                last flag.
//  Ports       : clk, rst_n          - clock, synchronous active-low reset
//                start               - one-cycle pulse that begins a drain
//                ofm_size, num_filter- OFM geometry, sampled at start
//                re_a, addr_a, dout_a- OFM RAM port A (1-cycle read latency)
//                out_valid/out_ready - beat handshake
//                out_data/out_count/out_last - beat payload, element count,
//                                      final-beat flag
//                busy, done          - drain in progress / completion pulse
//  Revision    : 1.0 - initial release
// ============================================================================
module ofm_read_controller #(
  parameter int DATA_WIDTH   = 16,
  parameter int INOUT_WIDTH  = 256,
  parameter int OFM_RAM_SIZE = 62500,
  localparam int ELEMS = INOUT_WIDTH / DATA_WIDTH,
  localparam int AW    = $clog2(OFM_RAM_SIZE)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [8:0]             ofm_size,
  input  logic [10:0]            num_filter,
  output logic                   re_a,
  output logic [AW-1:0]          addr_a,
  input  logic [INOUT_WIDTH-1:0] dout_a,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [INOUT_WIDTH-1:0] out_data,
  output logic [4:0]             out_count,
  output logic                   out_last,
  output logic                   busy,
  output logic                   done
);

  localparam int EL_SH = $clog2(ELEMS);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t state, state_nx;

  // Sizing, evaluated from the live inputs; only used on the start cycle.
  logic [AW:0]   total;
  logic [AW+1:0] total_rnd;
  logic [AW:0]   beats;
  logic [4:0]    last_cnt;

  assign total     = (AW+1)'(ofm_size) * (AW+1)'(ofm_size) * (AW+1)'(num_filter);
  assign total_rnd = {1'b0, total} + (AW+2)'(ELEMS - 1);
  assign beats     = (AW+1)'(total_rnd >> EL_SH);
  assign last_cnt  = (total[EL_SH-1:0] == '0) ? 5'(ELEMS) : 5'(total[EL_SH-1:0]);

  // Latched drain configuration and read pointer.
  logic [AW:0]   reads_left;
  logic [4:0]    last_cnt_r;
  logic [AW-1:0] addr_r;

  // In-flight read: dout_a is valid the cycle after issue; its tag travels along.
  logic       inflight;
  logic [4:0] inf_cnt;
  logic       inf_last;

  // 2-entry beat FIFO.
  logic [INOUT_WIDTH-1:0] fifo_data [2];
  logic [4:0]             fifo_cnt  [2];
  logic                   fifo_last [2];
  logic                   rd_ptr, wr_ptr;
  logic [1:0]             occ;

  logic                   fifo_empty;
  logic                   pop, push, fifo_pop, issue, final_rd;
  logic [INOUT_WIDTH-1:0] head_data;
  logic [4:0]             head_cnt;
  logic                   head_last;

  // When the FIFO is empty the returning RAM word is presented directly, so a
  // beat is visible the cycle its data arrives from the RAM.
  assign fifo_empty = (occ == 2'd0);
  assign head_data  = fifo_empty ? dout_a   : fifo_data[rd_ptr];
  assign head_cnt   = fifo_empty ? inf_cnt  : fifo_cnt[rd_ptr];
  assign head_last  = fifo_empty ? inf_last : fifo_last[rd_ptr];

  assign out_valid = !fifo_empty || inflight;
  assign out_data  = out_valid ? head_data : '0;
  assign out_count = out_valid ? head_cnt  : '0;
  assign out_last  = out_valid ? head_last : 1'b0;

  assign pop      = out_valid && out_ready;
  assign fifo_pop = pop && !fifo_empty;
  // Returning word is stored unless it was consumed directly in bypass.
  assign push     = inflight && !(fifo_empty && pop);

  // Buffered + in-flight never exceeds 2; a slot freed by this cycle's pop may
  // be refilled at once, which sustains one beat per cycle.
  assign final_rd = (reads_left == (AW+1)'(1));
  assign issue    = (state == READ) &&
                    ((({1'b0, occ} + {2'b00, inflight}) < 3'd2) || pop);

  assign re_a   = issue;
  assign addr_a = addr_r;
  assign busy   = (state == READ) || (state == DRAIN);
  assign done   = (state == DONE);

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = (total == '0) ? DONE : READ;
      READ:    if (issue && final_rd) state_nx = DRAIN;
      DRAIN:   if (pop && head_last) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      reads_left <= '0;
      last_cnt_r <= '0;
      addr_r     <= '0;
      inflight   <= 1'b0;
      inf_cnt    <= '0;
      inf_last   <= 1'b0;
      fifo_cnt[0]  <= '0;
      fifo_cnt[1]  <= '0;
      fifo_last[0] <= 1'b0;
      fifo_last[1] <= 1'b0;
      rd_ptr     <= 1'b0;
      wr_ptr     <= 1'b0;
      occ        <= '0;
    end else begin
      state <= state_nx;

      if (state == IDLE && start) begin
        addr_r     <= '0;
        reads_left <= beats;
        last_cnt_r <= last_cnt;
      end

      if (issue) begin
        addr_r     <= addr_r + AW'(ELEMS);
        reads_left <= reads_left - (AW+1)'(1);
      end

      inflight <= issue;
      inf_cnt  <= final_rd ? last_cnt_r : 5'(ELEMS);
      inf_last <= final_rd;

      if (push) begin
        fifo_cnt[wr_ptr]  <= inf_cnt;
        fifo_last[wr_ptr] <= inf_last;
        wr_ptr            <= ~wr_ptr;
      end
      if (fifo_pop) rd_ptr <= ~rd_ptr;
      occ <= occ + {1'b0, push} - {1'b0, fifo_pop};
    end
  end

  // Payload storage needs no reset: it is never visible while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push) fifo_data[wr_ptr] <= dout_a;
  end

endmodule
`default_nettype wire

// File: tb/tb_ofm_read_controller.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ofm_read_controller
//  Description : Self-checking bench for ofm_read_controller. A RAM model
//                answers port-A reads; expected beats are derived from the
//                OFM geometry and RAM contents.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ofm_read_controller;

  localparam int DW   = 16;
  localparam int IW   = 256;
  localparam int AW   = 16;
  localparam int MEMN = 1024;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic [8:0]    ofm_size;
  logic [10:0]   num_filter;
  logic          re_a;
  logic [AW-1:0] addr_a;
  logic [IW-1:0] dout_a;
  logic          out_valid;
  logic          out_ready;
  logic [IW-1:0] out_data;
  logic [4:0]    out_count;
  logic          out_last;
  logic          busy;
  logic          done;

  logic [DW-1:0] mem [MEMN];

  int n_cmp;
  int n_err;

  ofm_read_controller #(
    .DATA_WIDTH  (DW),
    .INOUT_WIDTH (IW),
    .OFM_RAM_SIZE(62500)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .ofm_size  (ofm_size),
    .num_filter(num_filter),
    .re_a      (re_a),
    .addr_a    (addr_a),
    .dout_a    (dout_a),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_count (out_count),
    .out_last  (out_last),
    .busy      (busy),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM model: 16 consecutive elements, one cycle after the read enable.
  always @(posedge clk) begin
    if (re_a) begin
      for (int i = 0; i < 16; i++)
        dout_a[i*DW +: DW] <= mem[(int'(addr_a) + i) % MEMN];
    end
  end

  task automatic check(input string tag, input logic [IW-1:0] got, input logic [IW-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // mode: 0 = ready always high, 1 = random ready, 2 = ready low for 20 cycles
  // abort_at: beats accepted before a mid-drain reset (-1 = none)
  task automatic drain(input int sz, input int nf, input int mode,
                       input int abort_at, input bit inject_start);
    int total, beats, lastc, issued, acc, last_acc, budget;
    bit fin, aborted, stall, pop;
    logic [IW-1:0] sdata, ed, mk;
    logic [4:0] scnt;
    logic slast;

    total    = sz * sz * nf;
    beats    = (total + 15) / 16;
    lastc    = (total % 16 == 0) ? 16 : total % 16;
    issued   = 0;
    acc      = 0;
    last_acc = -1;
    budget   = 4 * beats + 60;
    fin      = 0;
    aborted  = 0;
    stall    = 0;
    sdata    = '0;
    scnt     = '0;
    slast    = 0;

    @(negedge clk);
    ofm_size   = 9'(sz);
    num_filter = 11'(nf);
    start      = 1'b1;
    @(negedge clk);
    start      = 1'b0;
    // Scramble the configuration inputs: the drain must use the latched values.
    ofm_size   = 9'($urandom);
    num_filter = 11'($urandom);

    for (int cyc = 0; cyc < budget; cyc++) begin
      if (cyc > 0) @(negedge clk);
      start = 1'b0;
      case (mode)
        1:       out_ready = 1'($urandom_range(0, 1));
        2:       out_ready = (cyc >= 20);
        default: out_ready = 1'b1;
      endcase
      #1;
      pop = out_valid && out_ready;

      if (cyc == 0) begin
        if (total > 0) check("first_re", IW'(re_a), IW'(1));
        else           check("zero_done", IW'(done), IW'(1));
      end
      if (cyc == 1 && total > 0) check("first_valid", IW'(out_valid), IW'(1));
      if (total == 0) check("zero_quiet", IW'(re_a | out_valid), IW'(0));

      if (re_a) begin
        check("re_slot", IW'((issued - acc >= 2) && !pop), IW'(0));
        check("addr", IW'(addr_a), IW'(issued * 16));
        issued++;
        check("read_count", IW'(issued <= beats), IW'(1));
      end

      if (stall) begin
        check("hold_valid", IW'(out_valid), IW'(1));
        check("hold_data", out_data, sdata);
        check("hold_cnt", IW'({out_last, out_count}), IW'({slast, scnt}));
      end

      if (mode == 2 && cyc == 19) begin
        check("stall_reads", IW'(issued <= 2), IW'(1));
        check("stall_valid", IW'(out_valid), IW'(1));
      end

      if (pop) begin
        ed = '0;
        mk = '0;
        for (int i = 0; i < 16; i++) begin
          if (i < ((acc == beats - 1) ? lastc : 16)) begin
            ed[i*DW +: DW] = mem[(acc * 16 + i) % MEMN];
            mk[i*DW +: DW] = '1;
          end
        end
        check("beat_cnt", IW'(out_count), IW'((acc == beats - 1) ? lastc : 16));
        check("beat_last", IW'(out_last), IW'(acc == beats - 1));
        check("beat_data", out_data & mk, ed);
        if (out_last) last_acc = cyc;
        acc++;
      end

      if (abort_at >= 0 && acc == abort_at) begin
        rst_n   = 1'b0;
        aborted = 1;
        break;
      end

      if (done) begin
        check("beats", IW'(acc), IW'(beats));
        check("done_lat", IW'(cyc), IW'(last_acc + 1));
        check("done_busy", IW'(busy), IW'(0));
        fin = 1;
        break;
      end

      stall = out_valid && !out_ready;
      sdata = out_data;
      scnt  = out_count;
      slast = out_last;

      if (inject_start && cyc == 6) start = 1'b1;
    end

    if (aborted) begin
      out_ready = 1'b0;
      @(negedge clk);
      #1;
      check("rst_outs", IW'({re_a, addr_a, out_valid, out_count, out_last, busy, done}), IW'(0));
      check("rst_data", out_data, IW'(0));
      rst_n = 1'b1;
    end else if (!fin) begin
      check("timeout", IW'(0), IW'(1));
    end else begin
      @(negedge clk);
      #1;
      check("done_pulse", IW'(done), IW'(0));
    end
    out_ready = 1'b0;
  endtask

  initial begin
    n_cmp      = 0;
    n_err      = 0;
    rst_n      = 1'b0;
    start      = 1'b0;
    out_ready  = 1'b1;
    ofm_size   = '0;
    num_filter = '0;
    for (int i = 0; i < MEMN; i++) mem[i] = DW'($urandom);

    repeat (3) @(negedge clk);
    #1;
    check("reset_outs", IW'({re_a, addr_a, out_valid, out_count, out_last, busy, done}), IW'(0));
    check("reset_data", out_data, IW'(0));
    rst_n = 1'b1;

    drain(4, 2, 0, -1, 0);
    drain(3, 1, 0, -1, 0);
    drain(13, 3, 1, -1, 1);
    drain(8, 4, 2, -1, 0);
    drain(5, 0, 0, -1, 0);
    drain(8, 4, 0, 5, 0);
    drain(8, 4, 0, -1, 0);
    for (int k = 0; k < 4; k++)
      drain($urandom_range(1, 7), $urandom_range(1, 8), 1, -1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
